// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: single-outstanding word bus with byte strobes,
// load alignment/extension into a registered write-back port, fault on bad access.
module rv32i_lsu (
  input  logic        sys_clk,
  input  logic        sys_reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] imm,
  input  logic [31:0] sdata,
  input  logic [4:0]  rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WB, S_DONE, S_FAULT} state_t;

  state_t      state, state_next;
  logic [31:0] ea;
  logic [1:0]  off;
  logic        legal, misaligned;
  logic [3:0]  strb_next;
  logic [31:0] wdata_next;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;
  logic [31:0] load_val;

  always_comb begin
    ea  = base + imm;
    off = ea[1:0];
    case (funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = ~is_store;
      default:                legal = 1'b0;
    endcase
    misaligned = ((funct3[1:0] == 2'b01) && ea[0]) ||
                 ((funct3[1:0] == 2'b10) && (off != 2'b00));
  end

  always_comb begin
    strb_next  = '0;
    wdata_next = '0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          strb_next  = 4'b0001 << off;
          wdata_next = {4{sdata[7:0]}};
        end
        2'b01: begin
          strb_next  = 4'b0011 << off;
          wdata_next = {2{sdata[15:0]}};
        end
        default: begin
          strb_next  = 4'b1111;
          wdata_next = sdata;
        end
      endcase
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    lbyte = mem_rdata[7:0];
      2'd1:    lbyte = mem_rdata[15:8];
      2'd2:    lbyte = mem_rdata[23:16];
      default: lbyte = mem_rdata[31:24];
    endcase
    lhalf = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_val = {{24{lbyte[7]}}, lbyte};
      3'b001:  load_val = {{16{lhalf[15]}}, lhalf};
      3'b100:  load_val = {24'd0, lbyte};
      3'b101:  load_val = {16'd0, lhalf};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = (!legal || misaligned) ? S_FAULT : S_REQ;
      S_REQ:   if (mem_ready) state_next = mem_we ? S_DONE : S_WB;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) state <= S_IDLE;
    else           state <= state_next;
  end

  // Bus fields are latched only for accesses that will actually reach the bus.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      rd_q      <= '0;
      wb_rd     <= '0;
      wb_data   <= '0;
    end else begin
      if (state == S_IDLE && start && legal && !misaligned) begin
        mem_we    <= is_store;
        mem_addr  <= {ea[31:2], 2'b00};
        mem_wdata <= wdata_next;
        mem_wstrb <= strb_next;
        f3_q      <= funct3;
        off_q     <= off;
        rd_q      <= rd;
      end
      if (state == S_REQ && mem_ready && !mem_we) begin
        wb_data <= load_val;
        wb_rd   <= rd_q;
      end
    end
  end

  assign mem_req = (state == S_REQ);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_WB) || (state == S_DONE) || (state == S_FAULT);
  assign fault   = (state == S_FAULT);
  assign wb_we   = (state == S_WB) && (wb_rd != 5'd0);

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed testbench for rv32i_lsu with hand-computed expectations.
module tb_rv32i_lsu;

  logic        sys_clk, sys_reset, start, is_store;
  logic [2:0]  funct3;
  logic [31:0] base, imm, sdata;
  logic [4:0]  rd;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_we, busy, done, fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  rv32i_lsu dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset), .start(start), .is_store(is_store),
    .funct3(funct3), .base(base), .imm(imm), .sdata(sdata), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .done(done), .fault(fault)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Presents a request for one edge; returns in the first cycle after acceptance.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] b,
                       input logic [31:0] i, input logic [31:0] sd, input logic [4:0] r);
    start = 1'b1; is_store = st; funct3 = f3; base = b; imm = i; sdata = sd; rd = r;
    tick();
    start = 1'b0;
  endtask

  task automatic complete(input logic [31:0] rdata);
    mem_ready = 1'b1; mem_rdata = rdata;
    tick();
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    sys_reset = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({mem_req, mem_we, wb_we, busy, done, fault} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 000000", {mem_req, mem_we, wb_we, busy, done, fault});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, mem_wstrb, wb_rd, wb_data} !== '0) begin
      n_bad++; $display("FAIL reset_data: addr=%h wdata=%h wstrb=%b rd=%0d wbdata=%h want all zero",
                        mem_addr, mem_wdata, mem_wstrb, wb_rd, wb_data);
    end
    sys_reset = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    issue(1'b0, 3'b010, 32'h1000, 32'h8, 32'h0, 5'd5);
    n_cmp++;
    if ({mem_req, mem_we, busy, done, mem_wstrb} !== 8'b1010_0000 || mem_addr !== 32'h1008) begin
      n_bad++; $display("FAIL lw_req: req/we/busy/done/wstrb=%b addr=%h want 10100000 addr=00001008",
                        {mem_req, mem_we, busy, done, mem_wstrb}, mem_addr);
    end
    complete(32'hDEADBEEF);
    n_cmp++;
    if ({wb_we, done, fault, mem_req} !== 4'b1100 || wb_data !== 32'hDEADBEEF || wb_rd !== 5'd5) begin
      n_bad++; $display("FAIL lw_wb: we/done/fault/req=%b data=%h rd=%0d want 1100 deadbeef 5",
                        {wb_we, done, fault, mem_req}, wb_data, wb_rd);
    end
    tick();
    n_cmp++;
    if ({wb_we, done, busy} !== 3'b000 || wb_data !== 32'hDEADBEEF || wb_rd !== 5'd5) begin
      n_bad++; $display("FAIL lw_after: we/done/busy=%b data=%h rd=%0d want 000 deadbeef 5",
                        {wb_we, done, busy}, wb_data, wb_rd);
    end
  endtask

  task automatic test_load_extend();
    issue(1'b0, 3'b000, 32'h2000, 32'h3, 32'h0, 5'd6);
    n_cmp++;
    if (mem_addr !== 32'h2000) begin
      n_bad++; $display("FAIL lb_addr: got %h want 00002000", mem_addr);
    end
    complete(32'h80FFFF7F);
    n_cmp++;
    if (wb_data !== 32'hFFFFFF80 || wb_we !== 1'b1) begin
      n_bad++; $display("FAIL lb_data: got %h we=%b want ffffff80 we=1", wb_data, wb_we);
    end
    tick();
    issue(1'b0, 3'b100, 32'h2000, 32'h3, 32'h0, 5'd6);
    complete(32'h80FFFF7F);
    n_cmp++;
    if (wb_data !== 32'h00000080) begin
      n_bad++; $display("FAIL lbu_data: got %h want 00000080", wb_data);
    end
    tick();
    issue(1'b0, 3'b001, 32'h2000, 32'h2, 32'h0, 5'd6);
    complete(32'h80FFFF7F);
    n_cmp++;
    if (wb_data !== 32'hFFFF80FF) begin
      n_bad++; $display("FAIL lh_data: got %h want ffff80ff", wb_data);
    end
    tick();
    issue(1'b0, 3'b101, 32'h2000, 32'h0, 32'h0, 5'd6);
    complete(32'h80FFFF7F);
    n_cmp++;
    if (wb_data !== 32'h0000FF7F) begin
      n_bad++; $display("FAIL lhu_data: got %h want 0000ff7f", wb_data);
    end
    tick();
  endtask

  task automatic test_store();
    issue(1'b1, 3'b001, 32'hFFFFFFFE, 32'h4, 32'h1234ABCD, 5'd9);
    n_cmp++;
    if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h0 || mem_wstrb !== 4'b1100 ||
        mem_wdata !== 32'hABCDABCD) begin
      n_bad++; $display("FAIL sh_req: req/we=%b addr=%h wstrb=%b wdata=%h want 11 00000000 1100 abcdabcd",
                        {mem_req, mem_we}, mem_addr, mem_wstrb, mem_wdata);
    end
    complete(32'h0);
    n_cmp++;
    if ({done, wb_we, fault, mem_req} !== 4'b1000 || wb_data !== 32'h0000FF7F) begin
      n_bad++; $display("FAIL sh_done: done/we/fault/req=%b wbdata=%h want 1000 0000ff7f",
                        {done, wb_we, fault, mem_req}, wb_data);
    end
    tick();
    issue(1'b1, 3'b000, 32'h10, 32'h1, 32'hCAFE_0055, 5'd0);
    n_cmp++;
    if (mem_wstrb !== 4'b0010 || mem_wdata !== 32'h55555555 || mem_addr !== 32'h10) begin
      n_bad++; $display("FAIL sb_req: wstrb=%b wdata=%h addr=%h want 0010 55555555 00000010",
                        mem_wstrb, mem_wdata, mem_addr);
    end
    complete(32'h0);
    tick();
    issue(1'b1, 3'b010, 32'h20, 32'h0, 32'h87654321, 5'd0);
    n_cmp++;
    if (mem_wstrb !== 4'b1111 || mem_wdata !== 32'h87654321) begin
      n_bad++; $display("FAIL sw_req: wstrb=%b wdata=%h want 1111 87654321", mem_wstrb, mem_wdata);
    end
    complete(32'h0);
    tick();
  endtask

  task automatic test_fault();
    logic [2:0] f3s [3];
    logic       sts [3];
    logic [31:0] offs [3];
    f3s[0] = 3'b010; sts[0] = 1'b0; offs[0] = 32'h1;
    f3s[1] = 3'b011; sts[1] = 1'b0; offs[1] = 32'h0;
    f3s[2] = 3'b100; sts[2] = 1'b1; offs[2] = 32'h0;
    for (int unsigned k = 0; k < 3; k++) begin
      issue(sts[k], f3s[k], 32'h100, offs[k], 32'h0, 5'd4);
      n_cmp++;
      if ({done, fault, mem_req, wb_we, busy} !== 5'b11001) begin
        n_bad++; $display("FAIL fault_%0d: done/fault/req/we/busy=%b want 11001",
                          k, {done, fault, mem_req, wb_we, busy});
      end
      tick();
      n_cmp++;
      if ({done, fault, mem_req, busy} !== 4'b0000 || wb_data !== 32'h0000FF7F) begin
        n_bad++; $display("FAIL fault_after_%0d: done/fault/req/busy=%b wbdata=%h want 0000 0000ff7f",
                          k, {done, fault, mem_req, busy}, wb_data);
      end
    end
  endtask

  task automatic test_wait_states();
    issue(1'b0, 3'b010, 32'h3000, 32'h10, 32'h0, 5'd7);
    for (int unsigned w = 0; w < 3; w++) begin
      n_cmp++;
      if ({mem_req, busy, done} !== 3'b110 || mem_addr !== 32'h3010 || mem_wstrb !== 4'b0000) begin
        n_bad++; $display("FAIL wait_hold_%0d: req/busy/done=%b addr=%h wstrb=%b want 110 00003010 0000",
                          w, {mem_req, busy, done}, mem_addr, mem_wstrb);
      end
      if (w == 0) begin
        start = 1'b1; is_store = 1'b1; funct3 = 3'b010; base = 32'h5000; imm = 32'h0; sdata = 32'h1;
      end
      tick();
      start = 1'b0;
    end
    complete(32'h0BAD_F00D);
    n_cmp++;
    if ({done, wb_we, mem_req} !== 3'b110 || wb_data !== 32'h0BADF00D || wb_rd !== 5'd7) begin
      n_bad++; $display("FAIL wait_done: done/we/req=%b data=%h rd=%0d want 110 0badf00d 7",
                        {done, wb_we, mem_req}, wb_data, wb_rd);
    end
    tick();
    n_cmp++;
    if ({busy, mem_req, done} !== 3'b000) begin
      n_bad++; $display("FAIL wait_no_queue: busy/req/done=%b want 000", {busy, mem_req, done});
    end
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    n_cmp++;
    if ({busy, mem_req, done, wb_we} !== 4'b0000) begin
      n_bad++; $display("FAIL ready_idle: busy/req/done/we=%b want 0000", {busy, mem_req, done, wb_we});
    end
    issue(1'b0, 3'b010, 32'h3000, 32'h0, 32'h0, 5'd0);
    complete(32'h13572468);
    n_cmp++;
    if ({done, wb_we} !== 2'b10 || wb_data !== 32'h13572468 || wb_rd !== 5'd0) begin
      n_bad++; $display("FAIL rd0: done/we=%b data=%h rd=%0d want 10 13572468 0",
                        {done, wb_we}, wb_data, wb_rd);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 3'b010, 32'h40, 32'h4, 32'h0, 5'd8);
    complete(32'hA5A5A5A5);
    tick();
    issue(1'b0, 3'b010, 32'h50, 32'h0, 32'h0, 5'd9);
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h50 || wb_data !== 32'hA5A5A5A5 || wb_rd !== 5'd8) begin
      n_bad++; $display("FAIL b2b_second: req=%b addr=%h wbdata=%h rd=%0d want 1 00000050 a5a5a5a5 8",
                        mem_req, mem_addr, wb_data, wb_rd);
    end
    complete(32'h5A5A5A5A);
    n_cmp++;
    if (wb_data !== 32'h5A5A5A5A || wb_rd !== 5'd9 || wb_we !== 1'b1) begin
      n_bad++; $display("FAIL b2b_wb: data=%h rd=%0d we=%b want 5a5a5a5a 9 1", wb_data, wb_rd, wb_we);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 3'b010, 32'h80, 32'h0, 32'h0, 5'd2);
    #2;
    sys_reset = 1'b1;
    #1;
    n_cmp++;
    if ({mem_req, busy} !== 2'b00) begin
      n_bad++; $display("FAIL reset_async: req/busy=%b want 00", {mem_req, busy});
    end
    mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_ready = 1'b0;
    sys_reset = 1'b0;
    tick();
    n_cmp++;
    if ({done, wb_we, busy, mem_req} !== 4'b0000 || wb_data !== 32'h0) begin
      n_bad++; $display("FAIL reset_no_wb: done/we/busy/req=%b data=%h want 0000 00000000",
                        {done, wb_we, busy, mem_req}, wb_data);
    end
    issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 5'd3);
    complete(32'h11223344);
    n_cmp++;
    if ({done, wb_we} !== 2'b11 || wb_data !== 32'h11223344 || wb_rd !== 5'd3) begin
      n_bad++; $display("FAIL reset_recover: done/we=%b data=%h rd=%0d want 11 11223344 3",
                        {done, wb_we}, wb_data, wb_rd);
    end
    tick();
  endtask

  initial begin
    sys_reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = '0;
    base = '0; imm = '0; sdata = '0; rd = '0; mem_ready = 1'b0; mem_rdata = '0;
    test_reset();
    test_lw();
    test_load_extend();
    test_store();
    test_fault();
    test_wait_states();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
